// File: rtl/step_ring_seq.sv
// step_ring_seq: N-position ring step sequencer; in clock, reset_n (async low), enable, a, dir, sat_mode, load, load_val[SW]; out state_o[SW], y[OUT_W], at_end, wrap_p; define STEP_EDGE_EN to step once per rising edge of a
module step_ring_seq #(
  parameter int N_STATES = 5,
  parameter int OUT_W = 8,
  localparam int SW = $clog2(N_STATES)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          a,
  input  logic          dir,
  input  logic          sat_mode,
  input  logic          load,
  input  logic [SW-1:0] load_val,
  output logic [SW-1:0] state_o,
  output logic [OUT_W-1:0] y,
  output logic          at_end,
  output logic          wrap_p
);
  localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);
  logic [SW-1:0] state;
  logic step;
`ifdef STEP_EDGE_EN
  logic a_d;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) a_d <= 1'b0;
    else a_d <= a;
  assign step = enable & a & ~a_d;
`else
  assign step = enable & a;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state  <= '0;
      wrap_p <= 1'b0;
    end else begin
      wrap_p <= 1'b0;
      if (load) state <= (load_val > LAST) ? LAST : load_val;
      else if (state > LAST) state <= '0;
      else if (step && dir) begin
        if (state != LAST) state <= state + SW'(1);
        else if (!sat_mode) begin
          state  <= '0;
          wrap_p <= 1'b1;
        end
      end else if (step) begin
        if (state != '0) state <= state - SW'(1);
        else if (!sat_mode) begin
          state  <= LAST;
          wrap_p <= 1'b1;
        end
      end
    end
  assign state_o = state;
  assign at_end  = dir ? (state == LAST) : (state == '0);
  for (genvar i = 0; i < OUT_W; i++) begin : g_y
    if (i < N_STATES - 1) begin : g_on
      assign y[i] = (state == SW'(i + 1));
    end else begin : g_off
      assign y[i] = 1'b0;
    end
  end
endmodule
